ahb2apb_async_fifo_rdctrl: RTL and testbench
============================================

AHB2APB_ASYNC_FIFO_RDCTRL -- requirements
Module: ahb2apb_async_fifo_rdctrl

Interface
REQ-001 Parameter AW, default 3: FIFO address width; depth 2^AW; pointers AW+1 bits.
REQ-002 Parameter DW, default 32: data width of FIFO memory and output register.
REQ-003 clk  input  1  read-domain clock; all state samples on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wptr_i  input  AW+1  Gray-coded write pointer from the write domain; asynchronous to clk.
REQ-006 rdata_i  input  DW  FIFO memory read data; combinational function of raddr_o.
REQ-007 rready_i  input  1  consumer accepts rdata_o this cycle.
REQ-008 ren_o  output  1  memory read strobe; pointer advances on this cycle.
REQ-009 raddr_o  output  AW  memory read address.
REQ-010 rptr_o  output  AW+1  registered Gray read pointer, sent to the write domain.
REQ-011 rempty_o  output  1  registered empty flag for memory entries not yet fetched.
REQ-012 rvalid_o  output  1  rdata_o holds a valid entry.
REQ-013 rdata_o  output  DW  registered show-ahead output data.
REQ-014 rlevel_o  output  AW+1  registered count of entries in memory not yet fetched, range 0..2^AW.

Function
REQ-015 wptr_i passes through exactly two clk flops to give wptr_sync; no logic between the stages.
REQ-016 Binary read pointer rbin; raddr_o = rbin[AW-1:0].
REQ-017 ren_o = ~rempty_o & (~rvalid_o | rready_i): fetch only when not empty and the output stage is free or draining.
REQ-018 nxt_rbin = rbin + ren_o, modulo 2^(AW+1); nxt_rgray = (nxt_rbin >> 1) ^ nxt_rbin; rbin and rptr_o load these every cycle.
REQ-019 rempty_o loads (nxt_rgray == wptr_sync) every cycle.
REQ-020 On ren_o: rdata_o loads rdata_i and rvalid_o is set to 1.
REQ-021 If ren_o = 0, rvalid_o = 1 and rready_i = 1: rvalid_o clears to 0 and rdata_o holds.
REQ-022 If rvalid_o = 1 and rready_i = 0: rdata_o and rvalid_o hold, and ren_o = 0.
REQ-023 Fetch and consume in the same cycle: rvalid_o stays 1 and rdata_o takes the next entry, with no bubble.
REQ-024 rlevel_o loads gray2bin(wptr_sync) - nxt_rbin, modulo 2^(AW+1).
REQ-025 Pointer wrap from 2^(AW+1)-1 to 0 is seamless; empty and level stay correct across the wrap.
REQ-026 Latency: an entry written in the write domain reaches rvalid_o no earlier than 4 clk edges after the wptr_i change (2 sync + 1 empty + 1 fetch).
REQ-027 rready_i while rvalid_o = 0 has no effect; underflow is impossible by construction.

Reset
REQ-028 On rst_n low, the following are cleared to 0: sync flops, rbin, rptr_o, rvalid_o, rdata_o and rlevel_o.
REQ-029 On rst_n low, rempty_o is set to 1.
REQ-030 Reset mid-operation discards any held output data; ren_o is 0 during reset.

Structure
REQ-031 Package ahb2apb_async_fifo_pkg holds the default AW and DW constants and the bin2gray/gray2bin functions, shared with the write controller.
REQ-032 Sub-module ahb2apb_sync2ff, a parameterized-width two-flop synchronizer, implements REQ-015.

Verification
REQ-033 Reset release with wptr_i = 0 -> rempty_o = 1, rvalid_o = 0, rlevel_o = 0, ren_o = 0 indefinitely.
REQ-034 Single write: wptr_i 0->1, rready_i = 0 -> rvalid_o = 1 on the 4th edge with rdata_o = mem[0], rptr_o = 1, then hold until rready_i.
REQ-035 Full FIFO: wptr_i = 4'b1100 (8 entries, AW = 3) -> rlevel_o reaches 8; with rready_i = 1, 8 entries stream on consecutive cycles, rptr_o ends at 4'b1100 and rempty_o = 1.
REQ-036 Backpressure: rready_i toggling 1/0 -> no entry lost or duplicated; rdata_o stable while rvalid_o & ~rready_i.
REQ-037 Wrap: 20 write/read rounds -> rbin wraps 15->0, rptr_o follows Gray sequence 1000->0000, data order preserved.
REQ-038 Assert rst_n low with rvalid_o = 1 and rlevel_o = 3 -> all outputs take reset values asynchronously.

Source files
------------

// File: rtl/ahb2apb_async_fifo_pkg.sv
// ahb2apb_async_fifo_pkg: shared async FIFO constants and Gray-code helpers
package ahb2apb_async_fifo_pkg;
  localparam int FIFO_AW = 3;
  localparam int FIFO_DW = 32;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/ahb2apb_sync2ff.sv
// ahb2apb_sync2ff: two-flop clock-domain synchronizer, no logic between stages
module ahb2apb_sync2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/ahb2apb_async_fifo_rdctrl.sv
// ahb2apb_async_fifo_rdctrl: async FIFO read-side control with a show-ahead
// output register; the fetch pointer runs one entry ahead of the consumer.
module ahb2apb_async_fifo_rdctrl
  import ahb2apb_async_fifo_pkg::*;
#(
  parameter int AW = FIFO_AW,
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW:0]   wptr_i,
  input  logic [DW-1:0] rdata_i,
  input  logic          rready_i,
  output logic          ren_o,
  output logic [AW-1:0] raddr_o,
  output logic [AW:0]   rptr_o,
  output logic          rempty_o,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW:0]   rlevel_o
);
  localparam int PW = AW + 1;
  logic [AW:0]   wptr_sync, rbin_q, rbin_d, rptr_q, rptr_d, rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  ahb2apb_sync2ff #(.W(PW)) u_wptr_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (wptr_i),
    .q_o  (wptr_sync)
  );
  // rempty_q resets high, which also keeps ren_o low throughout reset
  always_comb begin
    ren_o    = ~rempty_q & (~rvalid_q | rready_i);
    rbin_d   = rbin_q + PW'(ren_o);
    rptr_d   = PW'(bin2gray(32'(rbin_d)));
    rempty_d = rptr_d == wptr_sync;
    rvalid_d = ren_o | (rvalid_q & ~rready_i);
    rdata_d  = ren_o ? rdata_i : rdata_q;
    rlevel_d = PW'(gray2bin(32'(wptr_sync))) - rbin_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rlevel_q <= rlevel_d;
    end
  end
  assign raddr_o  = rbin_q[AW-1:0];
  assign rptr_o   = rptr_q;
  assign rempty_o = rempty_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rlevel_o = rlevel_q;
endmodule

// File: tb/tb_ahb2apb_async_fifo_rdctrl.sv
// tb_ahb2apb_async_fifo_rdctrl: directed vectors and sequences for the read controller
module tb_ahb2apb_async_fifo_rdctrl;
  localparam int AW = 3;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   wptr_i = '0;
  logic          rready_i = 1'b0;
  logic [DW-1:0] rdata_i, rdata_o;
  logic          ren_o, rempty_o, rvalid_o;
  logic [AW-1:0] raddr_o;
  logic [AW:0]   rptr_o, rlevel_o;
  logic [DW-1:0] mem [8];
  logic [DW-1:0] got[$], exp_q[$];
  logic [AW:0]   wbin = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign rdata_i = mem[raddr_o];

  ahb2apb_async_fifo_rdctrl #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wptr_i  (wptr_i),
    .rdata_i (rdata_i),
    .rready_i(rready_i),
    .ren_o   (ren_o),
    .raddr_o (raddr_o),
    .rptr_o  (rptr_o),
    .rempty_o(rempty_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .rlevel_o(rlevel_o)
  );

  typedef struct {
    logic [AW:0]   wptr;
    logic          rr;
    logic          valid;
    logic [DW-1:0] data;
    logic          empty;
    logic [AW:0]   level;
    logic [AW:0]   rptr;
    logic          ren;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    if (rvalid_o && rready_i) got.push_back(rdata_o);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 1'b1;
    wptr_i = gray(wbin);
  endtask

  task automatic chk_queues(input string name);
    chk({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_data%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    wptr_i = '0;
    rready_i = 1'b0;
    wbin = '0;
    got.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [AW:0]   prev_rptr;
    logic          seen_wrap;
    for (int i = 0; i < 8; i++) mem[i] = 32'hD0D0_0000 + i;
    vecs[0] = '{4'd0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd0, 1'b0};
    vecs[1] = '{4'd0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd0, 1'b0};
    vecs[2] = '{4'd1, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd0, 1'b0};
    vecs[3] = '{4'd1, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd0, 1'b0};
    vecs[4] = '{4'd1, 1'b0, 1'b0, 32'h0, 1'b0, 4'd1, 4'd0, 1'b1};
    vecs[5] = '{4'd1, 1'b0, 1'b1, 32'hD0D0_0000, 1'b1, 4'd0, 4'd1, 1'b0};
    vecs[6] = '{4'd1, 1'b0, 1'b1, 32'hD0D0_0000, 1'b1, 4'd0, 4'd1, 1'b0};
    vecs[7] = '{4'd1, 1'b1, 1'b0, 32'hD0D0_0000, 1'b1, 4'd0, 4'd1, 1'b0};
    vecs[8] = '{4'd1, 1'b1, 1'b0, 32'hD0D0_0000, 1'b1, 4'd0, 4'd1, 1'b0};
    do_reset();
    // single write and idle behaviour, one clock per vector
    for (int i = 0; i < 9; i++) begin
      wptr_i = vecs[i].wptr;
      rready_i = vecs[i].rr;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(rvalid_o), 64'(vecs[i].valid));
      chk($sformatf("vec%0d_data", i), 64'(rdata_o), 64'(vecs[i].data));
      chk($sformatf("vec%0d_empty", i), 64'(rempty_o), 64'(vecs[i].empty));
      chk($sformatf("vec%0d_level", i), 64'(rlevel_o), 64'(vecs[i].level));
      chk($sformatf("vec%0d_rptr", i), 64'(rptr_o), 64'(vecs[i].rptr));
      chk($sformatf("vec%0d_ren", i), 64'(ren_o), 64'(vecs[i].ren));
    end
    // full FIFO then streaming drain
    do_reset();
    for (int i = 0; i < 8; i++) push(32'hF000_0000 + i);
    chk("full_wptr", 64'(wptr_i), 64'h0C);
    repeat (3) tick();
    chk("full_level8", 64'(rlevel_o), 64'd8);
    chk("full_not_empty", 64'(rempty_o), 64'd0);
    tick();
    chk("full_first_valid", 64'(rvalid_o), 64'd1);
    chk("full_first_data", 64'(rdata_o), 64'hF000_0000);
    chk("full_level7", 64'(rlevel_o), 64'd7);
    repeat (2) tick();
    chk("full_hold_data", 64'(rdata_o), 64'hF000_0000);
    chk("full_hold_level", 64'(rlevel_o), 64'd7);
    rready_i = 1'b1;
    repeat (8) tick();
    chk("full_rptr_end", 64'(rptr_o), 64'h0C);
    chk("full_empty_end", 64'(rempty_o), 64'd1);
    chk("full_valid_end", 64'(rvalid_o), 64'd0);
    chk_queues("full_stream");
    // backpressure with rready toggling
    for (int i = 0; i < 6; i++) push(32'hB000_0000 + i);
    for (int i = 0; i < 40; i++) begin
      rready_i = (i % 2) == 0;
      if (rvalid_o && !rready_i) begin
        held = rdata_o;
        tick();
        chk($sformatf("bp_stable%0d", i), 64'(rdata_o), 64'(held));
        chk($sformatf("bp_valid%0d", i), 64'(rvalid_o), 64'd1);
      end else tick();
    end
    chk_queues("bp");
    // 20 single-entry rounds crossing the pointer wrap
    rready_i = 1'b1;
    seen_wrap = 1'b0;
    prev_rptr = rptr_o;
    for (int r = 0; r < 20; r++) begin
      push(32'hC0DE_0000 + r);
      for (int k = 0; k < 12 && got.size() == 0; k++) tick();
      chk($sformatf("wrap%0d_consumed", r), 64'(got.size()), 64'd1);
      if (got.size() > 0) chk($sformatf("wrap%0d_data", r), 64'(got[0]), 64'(exp_q[0]));
      chk($sformatf("wrap%0d_rptr", r), 64'(rptr_o), 64'(gray(wbin)));
      chk($sformatf("wrap%0d_empty", r), 64'(rempty_o), 64'd1);
      if (prev_rptr == 4'b1000 && rptr_o == 4'b0000) seen_wrap = 1'b1;
      prev_rptr = rptr_o;
      got.delete();
      exp_q.delete();
    end
    chk("wrap_seen", 64'(seen_wrap), 64'd1);
    // asynchronous reset while holding data with entries pending
    rready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hA500_0000 + i);
    repeat (4) tick();
    chk("arst_pre_valid", 64'(rvalid_o), 64'd1);
    chk("arst_pre_level", 64'(rlevel_o), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rvalid_o), 64'd0);
    chk("arst_data", 64'(rdata_o), 64'd0);
    chk("arst_empty", 64'(rempty_o), 64'd1);
    chk("arst_level", 64'(rlevel_o), 64'd0);
    chk("arst_rptr", 64'(rptr_o), 64'd0);
    chk("arst_ren", 64'(ren_o), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
